// File: rtl/reg_access_sequencer_if.sv
// Instruction handshake plus register-file port bundle for reg_access_sequencer.
// master = sequencer side, slave = fetch/decode + register-file side.
interface reg_access_sequencer_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 2
);
  logic              INSTR_VALID;
  logic              INSTR_READY;
  logic [9:0]        INSTR;
  logic [DATA_W-1:0] Q0;
  logic [DATA_W-1:0] Q1;
  logic              ENR0;
  logic              ENR1;
  logic [ADDR_W-1:0] RDA0;
  logic [ADDR_W-1:0] RDA1;
  logic              ENW;
  logic [ADDR_W-1:0] WRA;
  logic [DATA_W-1:0] D;
  logic              CARRY;
  logic              DONE;

  modport master (
    input  INSTR_VALID, INSTR, Q0, Q1,
    output INSTR_READY, ENR0, ENR1, RDA0, RDA1, ENW, WRA, D, CARRY, DONE
  );

  modport slave (
    output INSTR_VALID, INSTR, Q0, Q1,
    input  INSTR_READY, ENR0, ENR1, RDA0, RDA1, ENW, WRA, D, CARRY, DONE
  );
endinterface

// File: rtl/reg_access_sequencer.sv
// Sequences read/execute/write-back of one micro-instruction against a 4-entry register file.
// Accept-to-DONE: 4 cycles ADD/MOV, 2 LDI, 1 NOP; INSTR_READY only in IDLE, so the source stalls while busy.
module reg_access_sequencer #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 2
) (
  input  logic                   CLKb,
  input  logic                   RSTb,
  reg_access_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  state_t            state;
  logic [1:0]        op_q;
  logic [1:0]        rx_q;
  logic [1:0]        ry_q;
  logic [DATA_W-1:0] d_q;
  logic              carry_q;
  logic              done_q;
  logic [DATA_W:0]   sum;

  assign sum = {1'b0, bus.Q0} + {1'b0, bus.Q1};

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state   <= IDLE;
      op_q    <= OP_NOP;
      rx_q    <= '0;
      ry_q    <= '0;
      d_q     <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.INSTR_VALID) begin
            op_q <= bus.INSTR[9:8];
            rx_q <= bus.INSTR[7:6];
            ry_q <= bus.INSTR[5:4];
            case (bus.INSTR[9:8])
              OP_NOP: done_q <= 1'b1;
              OP_LDI: begin
                d_q   <= {{(DATA_W-4){1'b0}}, bus.INSTR[3:0]};
                state <= WRITE;
              end
              default: state <= READ;
            endcase
          end
        end
        READ: state <= EXEC;
        EXEC: begin
          // MOV reads port 0 disabled, so Q0 is 0 and the sum is just Q1.
          d_q <= sum[DATA_W-1:0];
          if (op_q == OP_ADD) carry_q <= sum[DATA_W];
          state <= WRITE;
        end
        WRITE: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.INSTR_READY = (state == IDLE);
    bus.ENR1        = (state == READ);
    bus.ENR0        = (state == READ) && (op_q == OP_ADD);
    bus.ENW         = (state == WRITE);
    bus.RDA1        = bus.ENR1 ? ADDR_W'(ry_q) : '0;
    bus.RDA0        = bus.ENR0 ? ADDR_W'(rx_q) : '0;
    bus.WRA         = bus.ENW  ? ADDR_W'(rx_q) : '0;
    bus.D           = d_q;
    bus.CARRY       = carry_q;
    bus.DONE        = done_q;
  end
endmodule

// File: tb/tb_reg_access_sequencer.sv
// Bench for reg_access_sequencer: register-file stub, timeline reference model, directed and random traffic.
module tb_reg_access_sequencer;
  localparam int DW = 10;
  localparam int AW = 2;

  logic CLKb = 1'b1;
  logic RSTb = 1'b0;

  reg_access_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  reg_access_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (.CLKb(CLKb), .RSTb(RSTb), .bus(bus));

  always #5 CLKb = ~CLKb;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Register file stub: reads and writes on the falling edge, disabled read port returns 0.
  logic [DW-1:0] rf [4] = '{default: '0};
  logic          pl_en   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_dat  = '0;

  always @(negedge CLKb) begin
    if (pl_en) rf[pl_addr] <= pl_dat;
    else if (bus.ENW) rf[bus.WRA] <= bus.D;
    bus.Q0 <= bus.ENR0 ? rf[bus.RDA0] : '0;
    bus.Q1 <= bus.ENR1 ? rf[bus.RDA1] : '0;
  end

  // Reference model: architectural registers plus the timeline of the last accepted instruction.
  logic [DW-1:0] mreg [4] = '{default: '0};
  bit            chk_en = 1'b0;
  int            cyc = 0;
  int            acc = -1000;
  logic [1:0]    mop = 2'b00;
  logic [1:0]    mrx = 2'b00;
  logic [1:0]    mry = 2'b00;
  int            mres = 0;
  bit            mcarry_new = 1'b0;
  int            d_prev = 0;
  bit            c_prev = 1'b0;
  bit            committed = 1'b1;

  always @(posedge CLKb) begin
    int k, len, dfrom, sum;
    bit isrd, isadd, wr;
    bit e_ready, e_done, e_enr0, e_enr1, e_enw, e_carry;
    int e_rda0, e_rda1, e_wra, e_d;
    if (!RSTb) begin
      if (chk_en) begin
        chk("rst_enw", bus.ENW, 0);
        chk("rst_enr0", bus.ENR0, 0);
        chk("rst_enr1", bus.ENR1, 0);
        chk("rst_d", bus.D, 0);
        chk("rst_carry", bus.CARRY, 0);
        chk("rst_done", bus.DONE, 0);
      end
      acc = -1000; mop = 2'b00; d_prev = 0; c_prev = 1'b0; committed = 1'b1;
    end else begin
      k     = cyc - acc;
      isrd  = (mop == 2'b01) || (mop == 2'b10);
      isadd = (mop == 2'b10);
      wr    = (mop != 2'b00);
      len   = (mop == 2'b00) ? 1 : (mop == 2'b11) ? 2 : 4;
      dfrom = (mop == 2'b11) ? 1 : 3;
      e_ready = (k >= len);
      e_done  = (k == len);
      e_enr1  = isrd && (k == 1);
      e_enr0  = isadd && (k == 1);
      e_rda1  = e_enr1 ? int'(mry) : 0;
      e_rda0  = e_enr0 ? int'(mrx) : 0;
      e_enw   = wr && (k == len - 1);
      e_wra   = e_enw ? int'(mrx) : 0;
      e_d     = (wr && k >= dfrom) ? mres : d_prev;
      e_carry = (isadd && k >= 3) ? mcarry_new : c_prev;
      if (chk_en) begin
        chk("ready", bus.INSTR_READY, int'(e_ready));
        chk("done", bus.DONE, int'(e_done));
        chk("enr0", bus.ENR0, int'(e_enr0));
        chk("enr1", bus.ENR1, int'(e_enr1));
        chk("rda0", bus.RDA0, e_rda0);
        chk("rda1", bus.RDA1, e_rda1);
        chk("enw", bus.ENW, int'(e_enw));
        chk("wra", bus.WRA, e_wra);
        chk("d", bus.D, e_d);
        chk("carry", bus.CARRY, int'(e_carry));
      end
      if (wr && k >= len && !committed) begin
        mreg[mrx] = DW'(mres);
        committed = 1'b1;
      end
      if (pl_en) mreg[pl_addr] = pl_dat;
      if (e_ready && bus.INSTR_VALID) begin
        d_prev = e_d;
        c_prev = e_carry;
        mop = bus.INSTR[9:8];
        mrx = bus.INSTR[7:6];
        mry = bus.INSTR[5:4];
        sum = int'(mreg[bus.INSTR[5:4]]) + ((bus.INSTR[9:8] == 2'b10) ? int'(mreg[bus.INSTR[7:6]]) : 0);
        mres = (bus.INSTR[9:8] == 2'b11) ? int'(bus.INSTR[3:0]) : (sum % 1024);
        mcarry_new = (sum >= 1024);
        acc = cyc;
        committed = 1'b0;
      end
    end
    cyc++;
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge CLKb); #1;
    pl_en = 1'b1; pl_addr = a; pl_dat = v;
    @(negedge CLKb); #1;
    pl_en = 1'b0;
  endtask

  // Presents ins for one cycle; caller guarantees the sequencer is idle. Returns in cycle 1.
  task automatic issue(input logic [9:0] ins);
    @(negedge CLKb); #1;
    bus.INSTR_VALID = 1'b1; bus.INSTR = ins;
    @(negedge CLKb); #1;
    bus.INSTR_VALID = 1'b0;
  endtask

  initial begin
    int acc_at [3];
    int nacc, ndone;
    bus.INSTR_VALID = 1'b0;
    bus.INSTR = '0;
    repeat (3) @(negedge CLKb);
    @(posedge CLKb); #1;
    RSTb = 1'b1;
    chk_en = 1'b1;

    // Idle after reset with no traffic.
    repeat (10) @(posedge CLKb);
    chk("idle_ready", bus.INSTR_READY, 1);
    chk("idle_enw", bus.ENW, 0);
    chk("idle_d", bus.D, 0);
    chk("idle_carry", bus.CARRY, 0);

    // LDI R2,#0xA
    issue({2'b11, 2'd2, 2'd0, 4'hA});
    @(posedge CLKb);
    chk("ldi_enw", bus.ENW, 1);
    chk("ldi_wra", bus.WRA, 2);
    chk("ldi_d", bus.D, 10);
    @(posedge CLKb);
    chk("ldi_done", bus.DONE, 1);
    chk("ldi_enw_off", bus.ENW, 0);
    chk("ldi_rf2", rf[2], 10);

    // ADD R0,R1 with R0=0x3FF, R1=0x002
    preload(2'd0, 10'h3FF);
    preload(2'd1, 10'h002);
    issue({2'b10, 2'd0, 2'd1, 4'h0});
    @(posedge CLKb);
    chk("add_enr0", bus.ENR0, 1);
    chk("add_enr1", bus.ENR1, 1);
    chk("add_rda0", bus.RDA0, 0);
    chk("add_rda1", bus.RDA1, 1);
    repeat (2) @(posedge CLKb);
    chk("add_wra", bus.WRA, 0);
    chk("add_d", bus.D, 1);
    chk("add_carry", bus.CARRY, 1);
    @(posedge CLKb);
    chk("add_done", bus.DONE, 1);

    // MOV R3,R1 with R1=0x155
    preload(2'd1, 10'h155);
    issue({2'b01, 2'd3, 2'd1, 4'h0});
    @(posedge CLKb);
    chk("mov_enr0", bus.ENR0, 0);
    chk("mov_enr1", bus.ENR1, 1);
    chk("mov_rda1", bus.RDA1, 1);
    repeat (2) @(posedge CLKb);
    chk("mov_wra", bus.WRA, 3);
    chk("mov_d", 32'(bus.D), 32'h155);
    chk("mov_carry", bus.CARRY, 1);
    @(posedge CLKb);
    chk("mov_rf3", 32'(rf[3]), 32'h155);

    // Back-to-back ADD, LDI, NOP with INSTR_VALID held high.
    nacc = 0; ndone = 0;
    acc_at = '{default: -1};
    @(negedge CLKb); #1;
    bus.INSTR_VALID = 1'b1;
    bus.INSTR = {2'b10, 2'd2, 2'd3, 4'h0};
    for (int c = 0; c < 10; c++) begin
      bit took;
      @(posedge CLKb);
      took = bus.INSTR_READY && bus.INSTR_VALID;
      if (bus.DONE) ndone++;
      if (c >= 1 && c <= 3) chk("b2b_busy", bus.INSTR_READY, 0);
      if (took && nacc < 3) begin
        acc_at[nacc] = c;
        nacc++;
      end
      @(negedge CLKb); #1;
      if (took) begin
        if (nacc == 1) bus.INSTR = {2'b11, 2'd1, 2'd0, 4'h7};
        else if (nacc == 2) bus.INSTR = 10'b0;
        else bus.INSTR_VALID = 1'b0;
      end
    end
    bus.INSTR_VALID = 1'b0;
    chk("b2b_acc0", acc_at[0], 0);
    chk("b2b_acc1", acc_at[1], 4);
    chk("b2b_acc2", acc_at[2], 6);
    chk("b2b_dones", ndone, 3);

    // Reset during WRITE of ADD R0,R1 aborts the write.
    preload(2'd0, 10'h0AB);
    preload(2'd1, 10'h011);
    issue({2'b10, 2'd0, 2'd1, 4'h0});
    repeat (3) @(posedge CLKb);
    #2 RSTb = 1'b0;
    #1;
    chk("abort_enw", bus.ENW, 0);
    chk("abort_d", bus.D, 0);
    @(negedge CLKb);
    @(posedge CLKb); #1;
    RSTb = 1'b1;
    repeat (2) @(posedge CLKb);
    chk("abort_rf0", 32'(rf[0]), 32'h0AB);
    chk("abort_ready", bus.INSTR_READY, 1);
    chk("abort_done", bus.DONE, 0);
    chk("abort_d_idle", bus.D, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      @(negedge CLKb); #1;
      bus.INSTR_VALID = ($urandom % 4) != 0;
      bus.INSTR = 10'($urandom);
    end
    @(negedge CLKb); #1;
    bus.INSTR_VALID = 1'b0;
    repeat (6) @(posedge CLKb);
    for (int r = 0; r < 4; r++) chk("final_reg", rf[r], mreg[r]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_access_sequencer.md
Name: reg_access_sequencer

Overview:
- Drives the 4×10-bit register file's port signals (D, ENW, ENR0, ENR1, WRA, RDA0, RDA1) and consumes its registered read data (Q0, Q1).
- Accepts one 10-bit micro-instruction at a time over a valid/ready handshake.
- Sequences the read, execute and write-back phases, and signals completion.
- Sits between instruction fetch/decode and the register file.

Parameters:
- DATA_W, 10, register/data width.
- ADDR_W, 2, register address width (4 registers).

Ports:
- CLKb  in  1  clock; every flop updates on the falling edge.
- RSTb  in  1  asynchronous active-low reset.
- INSTR_VALID  in  1  instruction present.
- INSTR_READY  out  1  sequencer can accept an instruction.
- INSTR  in  10  instruction fields:
  - [9:8] OP: 00 NOP, 01 MOV, 10 ADD, 11 LDI.
  - [7:6] RX.
  - [5:4] RY.
  - [3:0] IMM.
- Q0  in  DATA_W  register file read port 0 data.
- Q1  in  DATA_W  register file read port 1 data.
- ENR0  out  1  read enable, port 0.
- ENR1  out  1  read enable, port 1.
- RDA0  out  ADDR_W  read address, port 0.
- RDA1  out  ADDR_W  read address, port 1.
- ENW  out  1  write enable.
- WRA  out  ADDR_W  write address.
- D  out  DATA_W  write data.
- CARRY  out  1  carry-out of the last ADD.
- DONE  out  1  one-cycle completion pulse.

Behaviour:
- Reset (RSTb=0, asynchronous):
  - State goes to IDLE; latched instruction, D, CARRY and DONE clear to 0.
  - All enables and addresses drop to 0 immediately; no write is issued.
  - Reset mid-operation aborts the instruction with no register write.
- States are IDLE, READ, EXEC, WRITE. Enables and addresses decode combinationally from state and the latched instruction.
- INSTR_READY=1 only in IDLE. An instruction is accepted on a falling edge with INSTR_VALID=1 in IDLE, and INSTR is latched on that edge.
- IDLE transitions:
  - NOP → stays in IDLE; DONE=1 next cycle.
  - MOV/ADD → READ.
  - LDI → WRITE, with D loaded as {6'b0, IMM} on the accept edge.
- READ:
  - ENR1=1, RDA1=RY.
  - ADD only: ENR0=1, RDA0=RX.
  - MOV: ENR0=0, so the register file returns Q0=0.
  - Next state is always EXEC. The register file registers Q0/Q1 on the edge leaving READ.
- EXEC:
  - All enables are 0; Q0/Q1 are valid.
  - On the exit edge, D ← (Q0+Q1) mod 2^10 (for MOV this equals Q1).
  - ADD only: CARRY ← bit 10 of the sum. MOV and LDI leave CARRY unchanged.
  - Next state is WRITE.
- WRITE:
  - ENW=1, WRA=RX, D stable.
  - On the exit edge the register file writes D, DONE is set to 1, and state returns to IDLE.
- DONE:
  - Registered; high for exactly one cycle after WRITE exit or after NOP acceptance, otherwise 0.
  - INSTR_READY is high during the DONE cycle, so back-to-back issue is allowed.
- D holds its last value outside WRITE.
- RDA0, RDA1 and WRA are 0 whenever their enable is 0.
- Latency from the accept edge to the register write edge:
  - ADD/MOV: 3 edges, i.e. 4 cycles accept-to-DONE.
  - LDI: 1 edge, i.e. 2 cycles accept-to-DONE.
  - NOP: DONE on the next cycle.
- RX==RY is legal: ADD R1,R1 doubles the register.
- INSTR and INSTR_VALID are ignored outside IDLE.

Test Plan:
- Reset is released and INSTR_VALID=0 → INSTR_READY=1; ENW, ENR0, ENR1, D, CARRY and DONE all 0 for 10 cycles.
- LDI R2,#0xA → exactly one cycle with ENW=1, WRA=2, D=0x00A; DONE pulses on the following cycle.
- Register file preloaded R0=0x3FF, R1=0x002, then ADD R0,R1 → READ shows ENR0=ENR1=1, RDA0=0, RDA1=1; WRITE shows D=0x001, WRA=0; CARRY=1.
- MOV R3,R1 with R1=0x155 → ENR0 stays 0; ENR1=1, RDA1=1; WRITE shows D=0x155, WRA=3; CARRY holds its previous value.
- INSTR_VALID held high with ADD, LDI, NOP back-to-back → accepts occur on cycles 0, 4, 6; INSTR_READY low during READ/EXEC/WRITE; three DONE pulses.
- RSTb asserted during WRITE of an ADD → ENW drops to 0 immediately; target register unchanged; after release the sequencer is in IDLE with D=0 and DONE=0.
